pdu_lqlist_iterator: RTL and testbench

//  Owns the logical-qubit list register that feeds pdu_lqindexer. Accepts one
//  NUM_LQ-bit LQ bitmap per transaction (valid/ready) and emits each set index in

---
 rtl/pdu_lqlist_iterator_pkg.sv | 13 +
 rtl/pdu_lqlist_iterator_if.sv | 30 +++
 rtl/pdu_lqlist_iterator_lqindexer.sv | 32 +++
 rtl/pdu_lqlist_iterator.sv | 100 ++++++++++
 tb/tb_pdu_lqlist_iterator.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/pdu_lqlist_iterator_pkg.sv
// Shared definitions for the logical-qubit list iterator: default sizes and
// the iterator FSM state encoding.
package pdu_lqlist_iterator_pkg;

    localparam int unsigned LQ_COUNT   = 8;
    localparam int unsigned LQ_ADDR_BW = 3;

    typedef enum logic {
        IDLE = 1'b0,
        ITER = 1'b1
    } lq_iter_state_e;

endpackage : pdu_lqlist_iterator_pkg

// File: rtl/pdu_lqlist_iterator_if.sv
// Handshake bundle between the PDU decode side (list in) and the per-LQ
// patch/address stage (index out).
interface pdu_lqlist_iterator_if
    import pdu_lqlist_iterator_pkg::*;
#(
    parameter int unsigned NUM_LQ    = LQ_COUNT,
    parameter int unsigned LQADDR_BW = LQ_ADDR_BW
);
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [NUM_LQ-1:0]    in_lqlist;
    logic                 out_valid;
    logic                 out_ready;
    logic [LQADDR_BW-1:0] out_lqidx;
    logic [LQADDR_BW:0]   out_seq;
    logic                 out_last;
    logic                 done;
    logic                 busy;

    modport master (
        output flush, in_valid, in_lqlist, out_ready,
        input  in_ready, out_valid, out_lqidx, out_seq, out_last, done, busy
    );

    modport slave (
        input  flush, in_valid, in_lqlist, out_ready,
        output in_ready, out_valid, out_lqidx, out_seq, out_last, done, busy
    );
endinterface : pdu_lqlist_iterator_if

// File: rtl/pdu_lqlist_iterator_lqindexer.sv
// Combinational LQ indexer: lowest set bit of the list and the list with
// that bit cleared.
module pdu_lqindexer
    import pdu_lqlist_iterator_pkg::*;
#(
    parameter int unsigned NUM_LQ    = LQ_COUNT,
    parameter int unsigned LQADDR_BW = LQ_ADDR_BW
) (
    input  logic [NUM_LQ-1:0]    lqlist,
    output logic [LQADDR_BW-1:0] lqidx,
    output logic [NUM_LQ-1:0]    next_lqlist
);

    localparam logic [NUM_LQ-1:0] LIST_ONE = NUM_LQ'(1);

    logic found;

    always_comb begin
        lqidx = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_LQ; i++) begin
            if (lqlist[i] && !found) begin
                lqidx = LQADDR_BW'(i);
                found = 1'b1;
            end
        end
    end

    // Clearing the lowest set bit: x & (x - 1).
    assign next_lqlist = lqlist & (lqlist - LIST_ONE);

endmodule : pdu_lqindexer

// File: rtl/pdu_lqlist_iterator.sv
// Logical-qubit list iterator: accepts an LQ bitmap and emits each selected
// index in ascending order over a valid/ready stream, then pulses done.
module pdu_lqlist_iterator
    import pdu_lqlist_iterator_pkg::*;
#(
    parameter int unsigned NUM_LQ    = LQ_COUNT,
    parameter int unsigned LQADDR_BW = LQ_ADDR_BW
) (
    input  logic                 clk,
    input  logic                 rst,
    pdu_lqlist_iterator_if.slave bus
);

    localparam int unsigned       SEQ_BW  = LQADDR_BW + 1;
    localparam logic [SEQ_BW-1:0] SEQ_ONE = SEQ_BW'(1);

    lq_iter_state_e       state_q, state_d;
    logic [NUM_LQ-1:0]    lqlist_q, lqlist_d;
    logic [SEQ_BW-1:0]    seq_q, seq_d;
    logic                 done_q, done_d;

    logic [LQADDR_BW-1:0] lqidx;
    logic [NUM_LQ-1:0]    next_lqlist;
    logic                 last_idx;

    pdu_lqindexer #(
        .NUM_LQ    (NUM_LQ),
        .LQADDR_BW (LQADDR_BW)
    ) u_lqindexer (
        .lqlist      (lqlist_q),
        .lqidx       (lqidx),
        .next_lqlist (next_lqlist)
    );

    assign last_idx = (next_lqlist == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            lqlist_q <= '0;
            seq_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lqlist_q <= lqlist_d;
            seq_q    <= seq_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        lqlist_d = lqlist_q;
        seq_d    = seq_q;
        done_d   = 1'b0;
        if (bus.flush) begin
            state_d  = IDLE;
            lqlist_d = '0;
            seq_d    = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        seq_d = '0;
                        // An empty list completes immediately without entering ITER.
                        if (bus.in_lqlist != '0) begin
                            lqlist_d = bus.in_lqlist;
                            state_d  = ITER;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                ITER: begin
                    if (bus.out_ready) begin
                        lqlist_d = next_lqlist;
                        seq_d    = seq_q + SEQ_ONE;
                        if (last_idx) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Index-side outputs are forced to zero outside ITER so IDLE looks like reset.
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == ITER);
        bus.busy      = (state_q == ITER);
        bus.out_lqidx = (state_q == ITER) ? lqidx : '0;
        bus.out_seq   = (state_q == ITER) ? seq_q : '0;
        bus.out_last  = (state_q == ITER) && last_idx;
        bus.done      = done_q;
    end

endmodule : pdu_lqlist_iterator

// File: tb/tb_pdu_lqlist_iterator.sv
// Directed bench for pdu_lqlist_iterator with a queue of expected indices.
module tb_pdu_lqlist_iterator;

    typedef struct packed {
        logic [2:0] idx;
        logic [3:0] seq;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;
    exp_t sb[$];

    pdu_lqlist_iterator_if #(.NUM_LQ(8), .LQADDR_BW(3)) bus ();

    pdu_lqlist_iterator #(
        .NUM_LQ    (8),
        .LQADDR_BW (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_list(input logic [7:0] l);
        exp_t e;
        int   n = 0;
        for (int i = 0; i < 8; i++) begin
            if (l[i]) begin
                e.idx  = i[2:0];
                e.seq  = n[3:0];
                e.last = ((l >> (i + 1)) == 8'h00);
                sb.push_back(e);
                n++;
            end
        end
    endtask

    task automatic send(input string tag, input logic [7:0] l);
        chk({tag, "_in_ready"}, {31'b0, bus.in_ready}, 32'd1);
        bus.in_valid  = 1'b1;
        bus.in_lqlist = l;
        push_list(l);
        step();
        bus.in_valid  = 1'b0;
    endtask

    task automatic check_front(input string tag);
        chk({tag, "_valid"}, {31'b0, bus.out_valid}, 32'd1);
        chk({tag, "_idx"},   {29'b0, bus.out_lqidx}, {29'b0, sb[0].idx});
        chk({tag, "_seq"},   {28'b0, bus.out_seq},   {28'b0, sb[0].seq});
        chk({tag, "_last"},  {31'b0, bus.out_last},  {31'b0, sb[0].last});
        chk({tag, "_in_ready"}, {31'b0, bus.in_ready}, 32'd0);
    endtask

    // Drain the scoreboard; out_ready follows pat (bit c%4 on cycle c).
    // With noise set, in_valid is held high with a nonzero list to prove it is ignored.
    task automatic drain(input string tag, input logic [3:0] pat, input bit noise,
                         input int exp_cycles);
        int  c = 0;
        bit  hs;
        while (sb.size() != 0) begin
            if (c >= 64) begin
                chk({tag, "_timeout"}, 32'd1, 32'd0);
                sb.delete();
                break;
            end
            bus.out_ready = pat[c % 4];
            bus.in_valid  = noise;
            bus.in_lqlist = 8'h3C;
            #1;
            check_front(tag);
            hs = bus.out_valid && bus.out_ready;
            step();
            if (hs) void'(sb.pop_front());
            c++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk({tag, "_cycles"}, c, exp_cycles);
        chk({tag, "_done"},     {31'b0, bus.done},      32'd1);
        chk({tag, "_idle_vld"}, {31'b0, bus.out_valid}, 32'd0);
        chk({tag, "_idle_rdy"}, {31'b0, bus.in_ready},  32'd1);
    endtask

    initial begin
        rst           = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_lqlist = 8'h00;
        bus.out_ready = 1'b0;
        step();
        step();
        chk("rst_in_ready",  {31'b0, bus.in_ready},  32'd1);
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_lqidx",     {29'b0, bus.out_lqidx}, 32'd0);
        chk("rst_seq",       {28'b0, bus.out_seq},   32'd0);
        chk("rst_last",      {31'b0, bus.out_last},  32'd0);
        chk("rst_done",      {31'b0, bus.done},      32'd0);
        chk("rst_busy",      {31'b0, bus.busy},      32'd0);
        rst = 1'b1;
        step();

        // 8'b1010_0100 at full rate: 2,5,7 in three cycles
        send("a4_full", 8'hA4);
        drain("a4_full", 4'b1111, 1'b0, 3);
        step();
        chk("a4_full_done_pulse", {31'b0, bus.done}, 32'd0);

        // Same list with stalls; in_valid held high throughout must be ignored
        send("a4_stall", 8'hA4);
        drain("a4_stall", 4'b1001, 1'b1, 5);
        step();
        chk("a4_stall_no_accept", {31'b0, bus.out_valid}, 32'd0);
        chk("a4_stall_done_pulse", {31'b0, bus.done}, 32'd0);

        // Empty list
        send("empty", 8'h00);
        chk("empty_valid",    {31'b0, bus.out_valid}, 32'd0);
        chk("empty_done",     {31'b0, bus.done},      32'd1);
        chk("empty_in_ready", {31'b0, bus.in_ready},  32'd1);
        step();
        chk("empty_done_pulse", {31'b0, bus.done},      32'd0);
        chk("empty_valid2",     {31'b0, bus.out_valid}, 32'd0);

        // All-ones then single-bit list, accepted in the bubble cycle
        send("ff", 8'hFF);
        drain("ff", 4'b1111, 1'b0, 8);
        send("b2b_01", 8'h01);
        drain("b2b_01", 4'b1111, 1'b0, 1);
        step();

        // Flush while index 5 is being offered
        send("flush", 8'hA4);
        bus.out_ready = 1'b1;
        #1;
        check_front("flush_first");
        step();
        void'(sb.pop_front());
        check_front("flush_at5");
        bus.flush     = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_lqlist = 8'h80;
        step();
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        sb.delete();
        chk("flush_valid",    {31'b0, bus.out_valid}, 32'd0);
        chk("flush_in_ready", {31'b0, bus.in_ready},  32'd1);
        chk("flush_done",     {31'b0, bus.done},      32'd0);
        chk("flush_busy",     {31'b0, bus.busy},      32'd0);
        send("post_flush", 8'h80);
        drain("post_flush", 4'b1111, 1'b0, 1);
        step();

        // Reset in the middle of a list
        send("midrst", 8'hFF);
        bus.out_ready = 1'b1;
        step();
        chk("midrst_busy_before", {31'b0, bus.busy}, 32'd1);
        rst = 1'b0;
        #1;
        chk("midrst_in_ready",  {31'b0, bus.in_ready},  32'd1);
        chk("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("midrst_done",      {31'b0, bus.done},      32'd0);
        chk("midrst_busy",      {31'b0, bus.busy},      32'd0);
        chk("midrst_seq",       {28'b0, bus.out_seq},   32'd0);
        step();
        bus.out_ready = 1'b0;
        rst = 1'b1;
        sb.delete();
        step();
        chk("midrst_stay_idle", {31'b0, bus.out_valid}, 32'd0);

        // a4, a4, empty, ff, 01, 80 each pulse done once; flush and reset never do
        chk("done_pulses", done_cnt, 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_pdu_lqlist_iterator
